pc_unit: RTL and testbench
==========================

Name: pc_unit

Overview:
- Parametrised program-counter unit for the pipelined MIPS core; successor to the fixed single-cycle PC register.
- Holds the fetch address and selects the next PC from sequential, branch, jump or register targets.
- Supports stall, exception entry and eret return.
- Captures a redirect that arrives during a stall and applies it once the stall releases.
- Drives the IM word index and an instruction-address-exception flag toward F-stage/CP0.

Parameters:
- ADDR_W, 32, address width in bits.
- RESET_ADDR, 32'h0000_3000, PC after reset; also the IM base address.
- EXC_ENTRY, 32'h0000_4180, exception handler entry address.
- IM_DEPTH, 4096, IM size in words; defines the legal fetch range.
- IDX_W, 12, width of the IM word index; must satisfy 2^IDX_W >= IM_DEPTH.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset; reset==0 clears state immediately.
- stall  in  1  hazard stall; hold PC.
- npc_sel  in  2  0=SEQ, 1=BRANCH, 2=JUMP, 3=REG.
- branch_target  in  ADDR_W  taken-branch address.
- jump_target  in  ADDR_W  j/jal address.
- reg_target  in  ADDR_W  jr/jalr address.
- exc_req  in  1  exception/interrupt; redirect to EXC_ENTRY.
- eret_req  in  1  return to epc.
- epc  in  ADDR_W  CP0 EPC value.
- pc  out  ADDR_W  current fetch address.
- pc_plus4  out  ADDR_W  pc+4, modulo 2^ADDR_W.
- im_index  out  IDX_W  ((pc-RESET_ADDR)>>2)[IDX_W-1:0].
- addr_exc  out  1  pc misaligned or outside the IM range.
- pending  out  1  a redirect is captured and waiting.

Behaviour:
- Reset (reset==0, asynchronous): pc=RESET_ADDR, pending=0, pending_addr=0. Derived outputs follow: pc_plus4=RESET_ADDR+4, im_index=0, addr_exc=0.
- target is combinational from npc_sel: BRANCH→branch_target, JUMP→jump_target, REG→reg_target. SEQ means no redirect.
- Per rising edge, priority highest first:
  1. exc_req: pc←EXC_ENTRY; pending←0. Overrides stall.
  2. eret_req: pc←epc; pending←0. Overrides stall.
  3. stall with npc_sel≠SEQ: pc held; pending_addr←target; pending←1. A newer redirect overwrites an older one.
  4. stall with npc_sel==SEQ: pc held; pending and pending_addr unchanged.
  5. npc_sel≠SEQ (no stall): pc←target; pending←0. A live redirect beats a stored one.
  6. pending==1: pc←pending_addr; pending←0.
  7. Otherwise: pc←pc+4.
- exc_req and eret_req both high: exc_req wins.
- Latency: every redirect takes effect on pc one cycle after it is sampled. A pending redirect takes effect on the first non-stalled edge.
- Arithmetic:
  - pc+4 wraps modulo 2^ADDR_W with no saturation.
  - im_index is computed from a modulo-2^ADDR_W subtraction, then truncated.
- addr_exc is combinational, asserted when any of:
  - pc[1:0]≠0;
  - pc<RESET_ADDR;
  - pc≥RESET_ADDR+4·IM_DEPTH.
- The PC still loads the faulting value; CP0 decides on the exception.
- reset deasserting mid-stall: state already cleared; normal operation resumes next edge.
- No X propagation: every output is driven from reset onward.

Decomposition:
- Shared package: NPC_SEQ/NPC_BRANCH/NPC_JUMP/NPC_REG codes (2-bit), default RESET_ADDR and EXC_ENTRY constants, reused by the controller and CP0.
- One combinational sub-module, npc_mux: npc_sel plus the three targets in, target and is_redirect out.
- The register, pending capture and priority logic stay in pc_unit.

Test Plan:
- Reset then 3 free-running cycles → pc 0x3000, 0x3004, 0x3008, 0x300C; im_index 0,1,2,3; addr_exc=0.
- At pc=0x3010 set npc_sel=BRANCH, branch_target=0x3040 for 1 cycle → next pc=0x3040, then 0x3044.
- Redirect captured during stall:
  - Stimulus: stall=1 for 3 cycles at pc=0x3020; JUMP to 0x3100 in cycle 1, REG to 0x3200 in cycle 2, SEQ in cycle 3; then stall=0.
  - Response: pc holds 0x3020 and pending=1 throughout the stall; first free edge gives pc=0x3200; pending=0.
- Exception and eret:
  - Stimulus: exc_req during stall with pending set; later eret_req with epc=0x3008.
  - Response: pc=0x4180, pending=0; then pc=0x3008.
  - Simultaneous exc_req+eret_req → 0x4180.
- Address exception: reg_target=0x3002 → addr_exc=1. reg_target=0x7000 → addr_exc=1, im_index=0x000 (wrapped). reg_target=0x2FFC → addr_exc=1.
- Async reset: pull reset low mid-cycle while pending=1 → pc=0x3000 and pending=0 before the next clock edge; resume 0x3004 after release.

Source files
------------

// File: rtl/pc_unit_pkg.sv
// ---------------------------------------------------------------------------
// pc_unit_pkg
//   Shared definitions for the program-counter unit, the pipeline controller
//   and CP0: next-PC select codes and the default reset / exception vectors.
// ---------------------------------------------------------------------------
package pc_unit_pkg;

    // Next-PC source select driven by the decode/controller stage.
    typedef enum logic [1:0] {
        NPC_SEQ    = 2'd0,   // pc + 4, no redirect
        NPC_BRANCH = 2'd1,   // taken conditional branch
        NPC_JUMP   = 2'd2,   // j / jal
        NPC_REG    = 2'd3    // jr / jalr
    } npc_sel_e;

    // Default PC after reset; also the instruction-memory base address.
    localparam logic [31:0] PC_RESET_ADDR = 32'h0000_3000;

    // Default exception / interrupt handler entry point.
    localparam logic [31:0] PC_EXC_ENTRY  = 32'h0000_4180;

endpackage : pc_unit_pkg

// File: rtl/pc_unit_if.sv
// ---------------------------------------------------------------------------
// pc_unit_if
//   Bundles the control and address signals exchanged between the pipeline
//   controller / CP0 (master) and the program-counter unit (slave).
//
//   master -> slave : stall, npc_sel, branch_target, jump_target, reg_target,
//                     exc_req, eret_req, epc
//   slave -> master : pc, pc_plus4, im_index, addr_exc, pending
// ---------------------------------------------------------------------------
interface pc_unit_if
    import pc_unit_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int IDX_W  = 12
);

    logic              stall;
    npc_sel_e          npc_sel;
    logic [ADDR_W-1:0] branch_target;
    logic [ADDR_W-1:0] jump_target;
    logic [ADDR_W-1:0] reg_target;
    logic              exc_req;
    logic              eret_req;
    logic [ADDR_W-1:0] epc;

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_plus4;
    logic [IDX_W-1:0]  im_index;
    logic              addr_exc;
    logic              pending;

    // Controller / CP0 side.
    modport master (
        output stall, npc_sel, branch_target, jump_target, reg_target,
               exc_req, eret_req, epc,
        input  pc, pc_plus4, im_index, addr_exc, pending
    );

    // Program-counter unit side.
    modport slave (
        input  stall, npc_sel, branch_target, jump_target, reg_target,
               exc_req, eret_req, epc,
        output pc, pc_plus4, im_index, addr_exc, pending
    );

endinterface : pc_unit_if

// File: rtl/pc_unit_npc_mux.sv
// ---------------------------------------------------------------------------
// npc_mux
//   Combinational next-PC target select.
//
//   npc_sel        in   select code (SEQ / BRANCH / JUMP / REG)
//   branch_target  in   taken-branch address
//   jump_target    in   j / jal address
//   reg_target     in   jr / jalr address
//   target         out  selected redirect address (zero when SEQ)
//   is_redirect    out  npc_sel requests a redirect
// ---------------------------------------------------------------------------
module npc_mux
    import pc_unit_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  npc_sel_e          npc_sel,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic [ADDR_W-1:0] reg_target,
    output logic [ADDR_W-1:0] target,
    output logic              is_redirect
);

    always_comb begin
        // NOTE: every output of a combinational block gets a default before
        // the case, so no path leaves it unassigned and no latch is inferred.
        target      = '0;
        is_redirect = 1'b0;
        case (npc_sel)
            NPC_BRANCH: begin
                target      = branch_target;
                is_redirect = 1'b1;
            end
            NPC_JUMP: begin
                target      = jump_target;
                is_redirect = 1'b1;
            end
            NPC_REG: begin
                target      = reg_target;
                is_redirect = 1'b1;
            end
            default: ;  // NPC_SEQ: no redirect
        endcase
    end

endmodule : npc_mux

// File: rtl/pc_unit.sv
// ---------------------------------------------------------------------------
// pc_unit
//   Program counter for the pipelined MIPS core. Holds the fetch address and
//   picks the next PC from sequential, branch, jump, register, exception and
//   eret sources. A redirect that arrives while the pipe is stalled is parked
//   and applied on the first non-stalled edge.
//
//   Parameters
//     ADDR_W      address width
//     RESET_ADDR  PC after reset and instruction-memory base
//     EXC_ENTRY   exception handler entry
//     IM_DEPTH    instruction-memory size in words (legal fetch range)
//     IDX_W       IM word-index width, 2**IDX_W >= IM_DEPTH
//
//   Ports
//     clk    in   clock, rising edge
//     reset  in   asynchronous active-low reset
//     bus    slave side of pc_unit_if (controls in; pc, pc_plus4, im_index,
//            addr_exc, pending out)
// ---------------------------------------------------------------------------
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(PC_RESET_ADDR),
    parameter logic [ADDR_W-1:0] EXC_ENTRY  = ADDR_W'(PC_EXC_ENTRY),
    parameter int                IM_DEPTH   = 4096,
    parameter int                IDX_W      = 12
) (
    input logic       clk,
    input logic       reset,
    pc_unit_if.slave  bus
);

    // One past the last legal fetch byte address; one extra bit so the
    // bound cannot overflow when the IM sits at the top of the address map.
    localparam logic [ADDR_W:0] IM_LIMIT =
        {1'b0, RESET_ADDR} + (ADDR_W+1)'(4 * IM_DEPTH);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              pending_q, pending_d;
    logic [ADDR_W-1:0] pending_addr_q, pending_addr_d;

    logic [ADDR_W-1:0] target;
    logic              is_redirect;

    npc_mux #(
        .ADDR_W (ADDR_W)
    ) u_npc_mux (
        .npc_sel       (bus.npc_sel),
        .branch_target (bus.branch_target),
        .jump_target   (bus.jump_target),
        .reg_target    (bus.reg_target),
        .target        (target),
        .is_redirect   (is_redirect)
    );

    // Next-state selection, highest priority first. Exception and eret act
    // even under stall and discard any parked redirect.
    always_comb begin
        pc_d           = pc_q;
        pending_d      = pending_q;
        pending_addr_d = pending_addr_q;

        if (bus.exc_req) begin
            pc_d      = EXC_ENTRY;
            pending_d = 1'b0;
        end else if (bus.eret_req) begin
            pc_d      = bus.epc;
            pending_d = 1'b0;
        end else if (bus.stall) begin
            // Hold the PC; the newest redirect seen during the stall wins.
            if (is_redirect) begin
                pending_addr_d = target;
                pending_d      = 1'b1;
            end
        end else if (is_redirect) begin
            // A live redirect is younger than anything parked.
            pc_d      = target;
            pending_d = 1'b0;
        end else if (pending_q) begin
            pc_d      = pending_addr_q;
            pending_d = 1'b0;
        end else begin
            pc_d = pc_q + ADDR_W'(4);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge inputs regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q           <= RESET_ADDR;
            pending_q      <= 1'b0;
            pending_addr_q <= '0;
        end else begin
            pc_q           <= pc_d;
            pending_q      <= pending_d;
            pending_addr_q <= pending_addr_d;
        end
    end

    assign bus.pc       = pc_q;
    assign bus.pc_plus4 = pc_q + ADDR_W'(4);
    assign bus.pending  = pending_q;

    // Word offset from the IM base, wrapping below the base, then truncated.
    assign bus.im_index = IDX_W'((pc_q - RESET_ADDR) >> 2);

    // The PC still loads a faulting address; CP0 decides what to do with it.
    assign bus.addr_exc = (pc_q[1:0] != 2'b00)
                        || (pc_q < RESET_ADDR)
                        || ({1'b0, pc_q} >= IM_LIMIT);

endmodule : pc_unit

// File: tb/tb_pc_unit.sv
// ---------------------------------------------------------------------------
// tb_pc_unit
//   Directed stimulus with hand-computed expectations. The stimulus process
//   drives inputs on the falling edge and queues what the DUT must show after
//   the next rising edge; a monitor pops and compares after each rising edge.
// ---------------------------------------------------------------------------
module tb_pc_unit;
    import pc_unit_pkg::*;

    typedef struct {
        logic [31:0] pc;
        logic        pending;
        logic        addr_exc;
        logic [11:0] im_index;
    } exp_t;

    logic clk;
    logic reset;
    int   n_total  = 0;
    int   n_passed = 0;
    exp_t sb[$];

    pc_unit_if #(.ADDR_W(32), .IDX_W(12)) bus ();

    pc_unit #(
        .ADDR_W     (32),
        .RESET_ADDR (32'h0000_3000),
        .EXC_ENTRY  (32'h0000_4180),
        .IM_DEPTH   (4096),
        .IDX_W      (12)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        else
            n_passed++;
    endtask

    task automatic check_all(input string tag, input exp_t e);
        check({tag, " pc"},       bus.pc,              e.pc);
        check({tag, " pc_plus4"}, bus.pc_plus4,        e.pc + 32'd4);
        check({tag, " pending"},  32'(bus.pending),    32'(e.pending));
        check({tag, " addr_exc"}, 32'(bus.addr_exc),   32'(e.addr_exc));
        check({tag, " im_index"}, 32'(bus.im_index),   32'(e.im_index));
    endtask

    // Monitor: one expectation per rising edge while the scoreboard holds any.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check_all("edge", e);
            end
        end
    end

    // Put tgt on the selected source only; the others carry decoys.
    task automatic drive(input logic st, input npc_sel_e sel,
                         input logic [31:0] tgt, input logic exc,
                         input logic eret, input logic [31:0] epc_v);
        bus.stall         = st;
        bus.npc_sel       = sel;
        bus.branch_target = (sel == NPC_BRANCH) ? tgt : 32'hDEAD_0000;
        bus.jump_target   = (sel == NPC_JUMP)   ? tgt : 32'hBEEF_0000;
        bus.reg_target    = (sel == NPC_REG)    ? tgt : 32'hCAFE_0000;
        bus.exc_req       = exc;
        bus.eret_req      = eret;
        bus.epc           = epc_v;
    endtask

    // Queue the expectation for the coming rising edge, then move on.
    task automatic step(input logic [31:0] e_pc, input logic e_pend,
                        input logic e_ae, input logic [11:0] e_idx);
        exp_t e;
        e.pc = e_pc; e.pending = e_pend; e.addr_exc = e_ae; e.im_index = e_idx;
        sb.push_back(e);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t r;
        reset = 1'b0;
        drive(1'b0, NPC_SEQ, 32'h0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        @(negedge clk);
        r.pc = 32'h3000; r.pending = 1'b0; r.addr_exc = 1'b0; r.im_index = 12'h000;
        check_all("reset", r);
        reset = 1'b1;

        // Free-running fetch.
        step(32'h3004, 0, 0, 12'h001);
        step(32'h3008, 0, 0, 12'h002);
        step(32'h300C, 0, 0, 12'h003);
        step(32'h3010, 0, 0, 12'h004);

        // Taken branch, then sequential.
        drive(0, NPC_BRANCH, 32'h3040, 0, 0, 0); step(32'h3040, 0, 0, 12'h010);
        drive(0, NPC_SEQ,    32'h0,    0, 0, 0); step(32'h3044, 0, 0, 12'h011);
        drive(0, NPC_JUMP,   32'h3020, 0, 0, 0); step(32'h3020, 0, 0, 12'h008);

        // Redirects during stall: newest captured, applied on release.
        drive(1, NPC_JUMP, 32'h3100, 0, 0, 0); step(32'h3020, 1, 0, 12'h008);
        drive(1, NPC_REG,  32'h3200, 0, 0, 0); step(32'h3020, 1, 0, 12'h008);
        drive(1, NPC_SEQ,  32'h0,    0, 0, 0); step(32'h3020, 1, 0, 12'h008);
        drive(0, NPC_SEQ,  32'h0,    0, 0, 0); step(32'h3200, 0, 0, 12'h080);
        step(32'h3204, 0, 0, 12'h081);

        // Live redirect beats a parked one.
        drive(1, NPC_JUMP,   32'h3300, 0, 0, 0); step(32'h3204, 1, 0, 12'h081);
        drive(0, NPC_BRANCH, 32'h3400, 0, 0, 0); step(32'h3400, 0, 0, 12'h100);

        // Exception under stall clears the parked redirect; then eret.
        drive(1, NPC_JUMP, 32'h3500, 0, 0, 0);      step(32'h3400, 1, 0, 12'h100);
        drive(1, NPC_SEQ,  32'h0,    1, 0, 0);      step(32'h4180, 0, 0, 12'h460);
        drive(0, NPC_SEQ,  32'h0,    0, 0, 0);      step(32'h4184, 0, 0, 12'h461);
        drive(0, NPC_SEQ,  32'h0,    0, 1, 32'h3008); step(32'h3008, 0, 0, 12'h002);
        drive(0, NPC_SEQ,  32'h0,    1, 1, 32'h3008); step(32'h4180, 0, 0, 12'h460);
        drive(1, NPC_JUMP, 32'h3700, 0, 1, 32'h300C); step(32'h300C, 0, 0, 12'h003);

        // Address exceptions and range boundaries.
        drive(0, NPC_REG, 32'h3002, 0, 0, 0);     step(32'h3002, 0, 1, 12'h000);
        drive(0, NPC_SEQ, 32'h0,    0, 0, 0);     step(32'h3006, 0, 1, 12'h001);
        drive(0, NPC_REG, 32'h7000, 0, 0, 0);     step(32'h7000, 0, 1, 12'h000);
        drive(0, NPC_REG, 32'h6FFC, 0, 0, 0);     step(32'h6FFC, 0, 0, 12'hFFF);
        drive(0, NPC_REG, 32'h2FFC, 0, 0, 0);     step(32'h2FFC, 0, 1, 12'hFFF);
        drive(0, NPC_REG, 32'hFFFF_FFFC, 0, 0, 0); step(32'hFFFF_FFFC, 0, 1, 12'h3FF);
        drive(0, NPC_SEQ, 32'h0,    0, 0, 0);     step(32'h0000_0000, 0, 1, 12'h400);
        drive(0, NPC_JUMP, 32'h3000, 0, 0, 0);    step(32'h3000, 0, 0, 12'h000);
        drive(0, NPC_SEQ, 32'h0,    0, 0, 0);     step(32'h3004, 0, 0, 12'h001);

        // Asynchronous reset mid-cycle with a redirect parked.
        drive(1, NPC_JUMP, 32'h3600, 0, 0, 0);    step(32'h3004, 1, 0, 12'h001);
        #2 reset = 1'b0;
        #1;
        r.pc = 32'h3000; r.pending = 1'b0; r.addr_exc = 1'b0; r.im_index = 12'h000;
        check_all("async_reset", r);
        @(negedge clk);
        reset = 1'b1;
        drive(0, NPC_SEQ, 32'h0, 0, 0, 0);
        step(32'h3004, 0, 0, 12'h001);
        step(32'h3008, 0, 0, 12'h002);

        @(negedge clk);
        check("scoreboard drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end

endmodule : tb_pc_unit
